// File: rtl/acc_sobel_gen.sv
// rtl/acc_sobel_gen.sv - 3x3 Sobel magnitude accelerator on a shared single-port word memory
// Optional binary threshold output: define ACC_SOBEL_GEN_THRESH_EN
module acc_sobel_gen #(
    parameter int IMG_W    = 352,
    parameter int IMG_H    = 288,
    parameter int PPW      = 4,
    parameter int ADDR_W   = 16,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = IMG_W * IMG_H / PPW,
    localparam int DATA_W  = 8 * PPW
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataR,
    output logic [DATA_W-1:0] dataW,
    output logic              en,
    output logic              we,
    input  logic              start,
`ifdef ACC_SOBEL_GEN_THRESH_EN
    input  logic [7:0]        thresh,
`endif
    output logic              finish,
    output logic              busy
);
    localparam int WPR = IMG_W / PPW;
    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = (WPR > 2) ? $clog2(WPR) : 1;
    localparam logic [ADDR_W-1:0] IN_B  = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] OUT_B = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] WPR_A = ADDR_W'(WPR);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZROW  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_FETCH = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];
    logic [DATA_W-1:0] res_q, res_d;
`ifdef ACC_SOBEL_GEN_THRESH_EN
    logic [7:0]        thresh_q, thresh_d;
`endif

    logic                en_c, we_c;
    logic [ADDR_W-1:0]   addr_c, rd_addr, out_addr, rd_col;
    logic [DATA_W-1:0]   dataw_c, calc_word;
    logic [1:0]          rd_row, ld_row, ld_col;
    logic [2:0]          slot;
    logic [3*DATA_W-1:0] line [3];
    logic [10:0]         mag;
    logic [7:0]          px;

    function automatic logic [10:0] sobel_mag(input logic [7:0] p11, p12, p13, p21,
                                              input logic [7:0] p23, p31, p32, p33);
        logic [10:0] gx, gy;
        gx = ({3'b0, p13} + {2'b0, p23, 1'b0} + {3'b0, p33})
           - ({3'b0, p11} + {2'b0, p21, 1'b0} + {3'b0, p31});
        gy = ({3'b0, p31} + {2'b0, p32, 1'b0} + {3'b0, p33})
           - ({3'b0, p11} + {2'b0, p12, 1'b0} + {3'b0, p13});
        if (gx[10]) gx = -gx;
        if (gy[10]) gy = -gy;
        return gx + gy;
    endfunction

    // LOAD walks column 0 then column 1 (rows r-1..r+1); FETCH walks column c+1.
    always_comb begin
        slot = cnt_q - 3'd1;
        if (state_q == S_LOAD) begin
            rd_row = (cnt_q < 3'd3) ? 2'(cnt_q) : 2'(cnt_q - 3'd3);
            rd_col = (cnt_q < 3'd3) ? '0 : ADDR_W'(1);
            ld_row = (slot < 3'd3) ? 2'(slot) : 2'(slot - 3'd3);
            ld_col = (slot < 3'd3) ? 2'd1 : 2'd2;
        end else begin
            rd_row = 2'(cnt_q);
            rd_col = ADDR_W'(c_q) + ADDR_W'(1);
            ld_row = 2'(slot);
            ld_col = 2'd2;
        end
        rd_addr  = IN_B + (ADDR_W'(r_q) + ADDR_W'(rd_row) - ADDR_W'(1)) * WPR_A + rd_col;
        out_addr = OUT_B + ADDR_W'(r_q) * WPR_A + ADDR_W'(c_q);
    end

    always_comb begin
        for (int i = 0; i < 3; i++) line[i] = {win_q[i][2], win_q[i][1], win_q[i][0]};
    end

    always_comb begin
        calc_word = '0;
        mag       = '0;
        px        = '0;
        for (int k = 0; k < PPW; k++) begin
            mag = sobel_mag(line[0][8*(PPW+k-1) +: 8], line[0][8*(PPW+k) +: 8],
                            line[0][8*(PPW+k+1) +: 8], line[1][8*(PPW+k-1) +: 8],
                            line[1][8*(PPW+k+1) +: 8], line[2][8*(PPW+k-1) +: 8],
                            line[2][8*(PPW+k) +: 8],   line[2][8*(PPW+k+1) +: 8]);
`ifdef ACC_SOBEL_GEN_THRESH_EN
            px = (mag >= {3'b0, thresh_q}) ? 8'hFF : 8'h00;
`else
            px = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
            if ((c_q == '0 && k == 0) || (c_q == CW'(WPR-1) && k == PPW-1)) px = 8'h00;
            calc_word[8*k +: 8] = px;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        res_d   = res_q;
`ifdef ACC_SOBEL_GEN_THRESH_EN
        thresh_d = thresh_q;
`endif
        en_c    = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        dataw_c = '0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ZROW;
                r_d     = '0;
                c_d     = '0;
`ifdef ACC_SOBEL_GEN_THRESH_EN
                thresh_d = thresh;
`endif
            end
            S_ZROW: begin
                en_c   = 1'b1;
                we_c   = 1'b1;
                addr_c = out_addr;
                if (c_q == CW'(WPR-1)) begin
                    c_d   = '0;
                    cnt_d = '0;
                    if (r_q == '0) begin
                        r_d     = RW'(1);
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            S_LOAD: begin
                if (cnt_q < 3'd6) begin
                    en_c   = 1'b1;
                    addr_c = rd_addr;
                end
                if (cnt_q == 3'd0) begin
                    for (int i = 0; i < 3; i++) win_d[i][0] = '0;
                end else begin
                    win_d[ld_row][ld_col] = dataR;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) state_d = S_CALC;
            end
            S_CALC: begin
                res_d   = calc_word;
                state_d = S_WR;
            end
            S_WR: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = out_addr;
                dataw_c = res_q;
                cnt_d   = '0;
                if (c_q != CW'(WPR-1)) begin
                    for (int i = 0; i < 3; i++) begin
                        win_d[i][0] = win_q[i][1];
                        win_d[i][1] = win_q[i][2];
                        win_d[i][2] = '0;
                    end
                    c_d     = c_q + CW'(1);
                    state_d = S_FETCH;
                end else begin
                    c_d     = '0;
                    r_d     = r_q + RW'(1);
                    state_d = (r_q == RW'(IMG_H-2)) ? S_ZROW : S_LOAD;
                end
            end
            S_FETCH: begin
                // Last column: the right window column is already zero from the shift.
                if (c_q == CW'(WPR-1)) begin
                    state_d = S_CALC;
                end else begin
                    if (cnt_q < 3'd3) begin
                        en_c   = 1'b1;
                        addr_c = rd_addr;
                    end
                    if (cnt_q != 3'd0) win_d[ld_row][ld_col] = dataR;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) state_d = S_CALC;
                end
            end
            S_DONE: if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
        res_q <= res_d;
`ifdef ACC_SOBEL_GEN_THRESH_EN
        thresh_q <= thresh_d;
`endif
    end

    // Outputs are forced quiet while reset is asserted so an in-flight write is dropped.
    assign en     = en_c & ~reset;
    assign we     = we_c & ~reset;
    assign addr   = reset ? '0 : addr_c;
    assign dataW  = reset ? '0 : dataw_c;
    assign finish = (state_q == S_DONE) & ~reset;
    assign busy   = (state_q != S_IDLE) & (state_q != S_DONE) & ~reset;
endmodule

// File: tb/tb_acc_sobel_gen.sv
// tb/tb_acc_sobel_gen.sv - randomized bench for acc_sobel_gen against a pixel-level reference model
module tb_acc_sobel_gen;
    localparam int IMG_W = 16, IMG_H = 5, PPW = 4, ADDR_W = 10, IN_BASE = 0, OUT_BASE = 'h100;
    localparam int WPR    = IMG_W / PPW;
    localparam int DATA_W = 8 * PPW;
    localparam int NWORDS = IMG_W * IMG_H / PPW;
    localparam int BOUND  = 2*WPR + (IMG_H-2)*(7 + 6*WPR) + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataR;
    logic [DATA_W-1:0] dataW;
    logic              en, we, finish, busy;
`ifdef ACC_SOBEL_GEN_THRESH_EN
    logic [7:0]        thresh = 8'h00;
`endif

    int checks = 0;
    int errors = 0;
    int th_cur = 0;
    int img [IMG_H][IMG_W];
    logic [DATA_W-1:0] img_w [NWORDS];
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic              load_req = 1'b0;

    int   bad_wr = 0, quiet_junk = 0, runs = 0;
    logic busy_prev = 1'b0;
    logic req_en = 1'b0, req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0;

    always #5 clk = ~clk;

    acc_sobel_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PPW(PPW), .ADDR_W(ADDR_W),
        .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .dataW(dataW),
        .en(en), .we(we), .start(start),
`ifdef ACC_SOBEL_GEN_THRESH_EN
        .thresh(thresh),
`endif
        .finish(finish), .busy(busy)
    );

    always @(negedge clk) begin
        req_en   = en;
        req_we   = we;
        req_addr = addr;
        req_data = dataW;
        if (!en && (addr != '0 || dataW != '0)) quiet_junk++;
        if (busy && !busy_prev) runs++;
        busy_prev = busy;
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[IN_BASE + i]  <= img_w[i];
                mem[OUT_BASE + i] <= 32'hA5A5_A5A5;
            end
        end else begin
            if (req_en && !req_we) dataR <= mem[req_addr];
            if (req_en && req_we) begin
                if (int'(req_addr) < OUT_BASE || int'(req_addr) >= OUT_BASE + NWORDS) bad_wr++;
                mem[req_addr] <= req_data;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_px(int x, int y);
        int gx, gy, mag;
        if (x == 0 || y == 0 || x == IMG_W-1 || y == IMG_H-1) return 0;
        gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
        gy = (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef ACC_SOBEL_GEN_THRESH_EN
        return (mag >= th_cur) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    // mode 0: uniform 0x80, 1: vertical step at x=4, 2: random
    task automatic load_image(input int mode);
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                img[y][x] = (mode == 0) ? 'h80 : (mode == 1) ? ((x >= 4) ? 'h40 : 0)
                          : int'($urandom_range(0, 255));
        for (int y = 0; y < IMG_H; y++)
            for (int wx = 0; wx < WPR; wx++)
                for (int k = 0; k < PPW; k++)
                    img_w[y*WPR + wx][8*k +: 8] = 8'(img[y][wx*PPW + k]);
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic set_thresh(input int th);
        th_cur = th;
`ifdef ACC_SOBEL_GEN_THRESH_EN
        thresh = 8'(th);
`endif
    endtask

    task automatic wait_finish(input string tag, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!finish && n < 2000);
        check({tag, "_finish"}, finish, 1);
    endtask

    task automatic run_once(input string tag);
        int n;
        int r0, b0;
        r0 = runs;
        b0 = bad_wr;
        @(posedge clk); #1 start = 1'b1;
        wait_finish(tag, n);
        check({tag, "_cycles_ok"}, (n - 1 <= BOUND), 1);
        check({tag, "_runs"}, runs - r0, 1);
        check({tag, "_stray_wr"}, bad_wr - b0, 0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_output(input string tag);
        logic [DATA_W-1:0] w;
        int diffs;
        for (int y = 0; y < IMG_H; y++)
            for (int wx = 0; wx < WPR; wx++) begin
                for (int k = 0; k < PPW; k++) w[8*k +: 8] = 8'(exp_px(wx*PPW + k, y));
                check($sformatf("%s_out_y%0d_w%0d", tag, y, wx), mem[OUT_BASE + y*WPR + wx], w);
            end
        diffs = 0;
        for (int i = 0; i < NWORDS; i++) if (mem[IN_BASE + i] !== img_w[i]) diffs++;
        check({tag, "_input_intact"}, diffs, 0);
    endtask

    initial begin
        int n, r0;
        logic seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {en, we, finish, busy, addr, dataW}, '0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {en, we, finish, busy}, '0);

        set_thresh('h40);
        load_image(0);
        run_once("uniform");
        check_output("uniform");

        load_image(1);
        run_once("step");
        check_output("step");
        check("step_x3", mem[OUT_BASE + WPR][31:24], 8'hFF);
        check("step_x4", mem[OUT_BASE + WPR + 1][7:0], 8'hFF);
        check("step_x5", mem[OUT_BASE + WPR + 1][15:8], 8'h00);

        for (int t = 0; t < 3; t++) begin
            set_thresh(int'($urandom_range(0, 600)) % 256);
            load_image(2);
            run_once($sformatf("rand%0d", t));
            check_output($sformatf("rand%0d", t));
        end

        // start held high through DONE must produce exactly one run
        load_image(2);
        r0 = runs;
        @(posedge clk); #1 start = 1'b1;
        wait_finish("hold", n);
        repeat (5) @(negedge clk);
        check("hold_finish_stays", {finish, busy}, 2'b10);
        check("hold_runs", runs - r0, 1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold_finish_drops", finish, 0);
        check_output("hold");

        // second run after a fresh start pulse, with a start pulse while busy ignored
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
        r0 = runs;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_finish("repulse", n);
        check("repulse_runs", runs - r0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("repulse_no_rerun", runs - r0, 1);
        check_output("repulse");

        // synchronous reset while the engine is fetching a mid-row column
        load_image(2);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            if (en && !we && (int'(addr) - IN_BASE) % WPR == 2) seen = 1'b1;
        end
        check("fetch_seen", seen, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_during", {en, we, finish, busy}, '0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_after", {en, we, finish, busy, addr, dataW}, '0);
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
        run_once("after_rst");
        check_output("after_rst");

        check("quiet_bus", quiet_junk, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
